// File: rtl/gcd_lcm_pkg.sv
// Shared types and constants for the GCD/LCM coprocessor.
// State encoding, mode and datapath-op selects.
package gcd_lcm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    GCD,
    DIV,
    MUL,
    FIN
  } state_t;

  localparam logic MODE_GCD = 1'b0;
  localparam logic MODE_LCM = 1'b1;

  localparam logic OP_DIV = 1'b0;
  localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/gcd_lcm_coproc_seq_divmul.sv
// Shared WIDTH-cycle shift-subtract divider / shift-add multiplier.
// One go pulse loads operands; done pulses once the last step lands.
module seq_divmul
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               op,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               done,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   rem,
  output logic [2*WIDTH-1:0] p
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] STEPS = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] arg;
  logic [WIDTH-1:0]   sh;
  logic [CNT_W-1:0]   cnt;
  logic               run;
  logic               op_r;
  logic               done_r;

  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [2*WIDTH-1:0] acc_n;
  logic [2*WIDTH-1:0] arg_n;
  logic [WIDTH-1:0]   sh_n;

  // One datapath step: restoring divide bit or shift-add multiply bit.
  always_comb begin
    trial = {acc[WIDTH-1:0], sh[WIDTH-1]};
    diff  = trial - arg[WIDTH:0];
    ge    = (trial >= arg[WIDTH:0]);
    acc_n = acc;
    arg_n = arg;
    sh_n  = sh;
    if (op_r == OP_DIV) begin
      acc_n = {{(WIDTH-1){1'b0}}, ge ? diff : trial};
      sh_n  = {sh[WIDTH-2:0], ge};
    end else begin
      if (sh[0]) acc_n = acc + arg;
      arg_n = arg << 1;
      sh_n  = sh >> 1;
    end
  end

  // Load on go, then step for exactly WIDTH cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      arg    <= '0;
      sh     <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      op_r   <= OP_DIV;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (go) begin
        op_r <= op;
        cnt  <= STEPS;
        run  <= 1'b1;
        acc  <= '0;
        sh   <= (op == OP_MUL) ? opb : opa;
        arg  <= {{WIDTH{1'b0}}, (op == OP_MUL) ? opa : opb};
      end else if (run) begin
        acc <= acc_n;
        arg <= arg_n;
        sh  <= sh_n;
        cnt <= cnt - ONE;
        if (cnt == ONE) begin
          run    <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign done = done_r;
  assign q    = sh;
  assign rem  = acc[WIDTH-1:0];
  assign p    = acc;

endmodule

// File: rtl/gcd_lcm_coproc.sv
// Multi-cycle GCD/LCM coprocessor: binary GCD, then a/g*b for LCM.
// Launched by a start pulse; busy/done handshake back to the core.
module gcd_lcm_coproc
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t state, state_n;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             mode_r;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [CNT_W-1:0] k;

  logic             zero;
  logic             eq;
  logic [WIDTH-1:0] g;

  logic               dm_go;
  logic               dm_op;
  logic [WIDTH-1:0]   dm_a;
  logic [WIDTH-1:0]   dm_b;
  logic               dm_done;
  logic [WIDTH-1:0]   dm_q;
  logic [WIDTH-1:0]   dm_rem;
  logic [2*WIDTH-1:0] dm_p;

  assign zero = (a_r == '0) || (b_r == '0);
  assign eq   = (x == y);
  assign g    = x << k;

  seq_divmul #(.WIDTH(WIDTH)) u_divmul (
    .clk   (clk),
    .reset (reset),
    .go    (dm_go),
    .op    (dm_op),
    .opa   (dm_a),
    .opb   (dm_b),
    .done  (dm_done),
    .q     (dm_q),
    .rem   (dm_rem),
    .p     (dm_p)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state sequencing.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = CHECK;
      CHECK:   state_n = zero ? FIN : GCD;
      GCD:     if (eq) state_n = (mode_r == MODE_LCM) ? DIV : FIN;
      DIV:     if (dm_done) state_n = MUL;
      MUL:     if (dm_done) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs and divide/multiply launch control.
  always_comb begin
    busy  = (state != IDLE);
    done  = (state == FIN);
    dm_go = ((state == GCD) && eq && (mode_r == MODE_LCM))
          || ((state == DIV) && dm_done);
    dm_op = (state == DIV) ? OP_MUL : OP_DIV;
    dm_a  = (state == DIV) ? dm_q : a_r;
    dm_b  = (state == DIV) ? b_r : g;
  end

  // Operand capture, Stein steps and result registers.
  // An odd-odd step subtracts and halves at once: the difference is even.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r      <= '0;
      b_r      <= '0;
      mode_r   <= MODE_GCD;
      x        <= '0;
      y        <= '0;
      k        <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_r    <= op_a;
            b_r    <= op_b;
            mode_r <= mode;
          end
        end
        CHECK: begin
          x <= a_r;
          y <= b_r;
          k <= '0;
          if (zero) begin
            result   <= (mode_r == MODE_LCM) ? '0 : (a_r | b_r);
            overflow <= 1'b0;
          end
        end
        GCD: begin
          if (eq) begin
            if (mode_r == MODE_GCD) begin
              result   <= g;
              overflow <= 1'b0;
            end
          end else if (!x[0] && !y[0]) begin
            x <= x >> 1;
            y <= y >> 1;
            k <= k + CNT_W'(1);
          end else if (!x[0]) begin
            x <= x >> 1;
          end else if (!y[0]) begin
            y <= y >> 1;
          end else if (x > y) begin
            x <= (x - y) >> 1;
          end else begin
            y <= (y - x) >> 1;
          end
        end
        MUL: begin
          if (dm_done) begin
            result   <= dm_p[WIDTH-1:0];
            overflow <= |dm_p[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  // g always divides a, so the quotient must be exact.
  always @(posedge clk) begin
    if (!reset && (state == DIV) && dm_done)
      assert (dm_rem == '0);
  end

endmodule
